// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: multicycle fetch/load/store responder driving one async 16-bit SRAM
// Ports: clk/rst (sync, active-high); fetch_req/fetch_addr -> ir_out/ir_valid;
//   data_req/data_we/data_addr/data_wdata -> data_rdata/data_valid; busy;
//   sram_addr/sram_wdata/sram_rdata and active-low sram_ce_n/sram_oe_n/sram_we_n.
// Option: define FETCH_HIT_EN for a one-entry fetch buffer that bypasses the SRAM on a hit.
module sram_mem_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 18,
  parameter int WAIT_CYCLES = 2,
  parameter logic [DATA_W-1:0] NOP_INSTR = 16'h0800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [15:0]       fetch_addr,
  output logic [DATA_W-1:0] ir_out,
  output logic              ir_valid,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [15:0]       data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_valid,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD    = 3'd1;
  localparam logic [2:0] S_SETUP = 3'd2;
  localparam logic [2:0] S_WR    = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [3:0] W_LOAD  = 4'(WAIT_CYCLES - 1);
  logic [2:0]        state_q, state_d;
  logic [3:0]        cnt_q;
  logic              fetch_q;
  logic [DATA_W-1:0] ir_q, rdata_q, wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic              ce_n_q, oe_n_q, we_n_q, ir_valid_q, data_valid_q;
  logic              idle, acc_data, acc_fetch, last, op_fetch, hit, rd_last;
  logic [DATA_W-1:0] hit_word;
  assign idle      = state_q == S_IDLE;
  assign acc_data  = idle && data_req;
  assign acc_fetch = idle && fetch_req && !data_req;
  assign last      = cnt_q == 4'd0;
  assign rd_last   = state_q == S_RD && last;
  // the op flag is only latched at accept, so look through to the request on that cycle
  assign op_fetch  = idle ? acc_fetch : fetch_q;
`ifdef FETCH_HIT_EN
  logic              buf_v_q;
  logic [15:0]       buf_tag_q;
  logic [DATA_W-1:0] buf_word_q;
  assign hit      = buf_v_q && buf_tag_q == fetch_addr;
  assign hit_word = buf_word_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_v_q    <= 1'b0;
      buf_tag_q  <= '0;
      buf_word_q <= '0;
    end else if (rd_last && fetch_q) begin
      buf_v_q    <= 1'b1;
      buf_tag_q  <= addr_q[15:0];
      buf_word_q <= sram_rdata;
    end else if (acc_data && data_we && data_addr == buf_tag_q) begin
      buf_v_q    <= 1'b0;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_word = '0;
`endif
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = acc_data ? (data_we ? S_SETUP : S_RD) : acc_fetch ? (hit ? S_DONE : S_RD) : S_IDLE;
      S_RD:    state_d = last ? S_DONE : S_RD;
      S_SETUP: state_d = S_WR;
      S_WR:    state_d = last ? S_HOLD : S_WR;
      S_HOLD:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      fetch_q      <= 1'b0;
      ir_q         <= NOP_INSTR;
      rdata_q      <= '0;
      wdata_q      <= '0;
      addr_q       <= '0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      ir_valid_q   <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= (state_d != state_q && (state_d == S_RD || state_d == S_WR)) ? W_LOAD : (last ? cnt_q : cnt_q - 4'd1);
      ce_n_q       <= state_d == S_IDLE || state_d == S_DONE;
      oe_n_q       <= state_d != S_RD;
      we_n_q       <= state_d != S_WR;
      ir_valid_q   <= state_d == S_DONE && op_fetch;
      data_valid_q <= state_d == S_DONE && !op_fetch;
      if (acc_data || acc_fetch) begin
        fetch_q <= acc_fetch;
        addr_q  <= ADDR_W'(acc_data ? data_addr : fetch_addr);
      end
      if (acc_data && data_we)
        wdata_q <= data_wdata;
      if (acc_fetch && hit)
        ir_q <= hit_word;
      if (rd_last && fetch_q)
        ir_q <= sram_rdata;
      if (rd_last && !fetch_q)
        rdata_q <= sram_rdata;
    end
  end
  assign ir_out     = ir_q;
  assign ir_valid   = ir_valid_q;
  assign data_rdata = rdata_q;
  assign data_valid = data_valid_q;
  assign busy       = !idle;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
endmodule
